multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Multi-cycle sequencer for the RV32I-subset datapath: FETCH/DECODE/EXEC/MEM/WB FSM sharing one memory port
//  (instr+data) via req/ready handshake. Decodes IR, drives datapath controls with existing encodings (ALUOp,
//  EXTOp, NPCOp, WDSel), flags illegal opcodes and bus timeouts. Sits between IR/PC/regfile/ALU/memory port.
// PARAMETERS
//  MEM_TIMEOUT  16  max cycles mem_req may wait for mem_ready before bus_err; 0 = never time out
// PORTS
//  clk        in   1  clock, rising edge
//  rst        in   1  synchronous reset, active-high
//  instr      in   32 IR contents; valid DECODE..WB
//  zero       in   1  ALU zero flag (EXEC)
//  mem_ready  in   1  memory ack for current req; ignored outside FETCH/MEM
//  mem_req    out  1  memory access request, held until mem_ready
//  mem_we     out  1  write strobe (store in MEM only)
//  iord       out  1  address select: 0=PC, 1=ALU result
//  ir_write   out  1  load IR with memory read data
//  pc_write   out  1  PC <= NPC this edge
//  reg_write  out  1  regfile write enable
//  alu_src    out  1  ALU B: 0=rs2, 1=immediate
//  alu_op     out  5  ALUOp code (nop 00000, lui 00001, add 00011, sub 00100, slt 01010, sltu 01011, xor 01100,
//                     or 01101, and 01110, sll 01111, srl 10000, sra 10001)
//  ext_op     out  6  one-hot EXTOp: ITYPE 010000, STYPE 001000, BTYPE 000100, UTYPE 000010, JTYPE 000001
//  npc_op     out  3  PLUS4 000, BRANCH 001, JUMP 010
//  wd_sel     out  2  ALU 00, MEM 01, PC 10
//  state      out  3  FSM state (debug)
//  instret    out  1  1-cycle pulse per retired instruction
//  illegal    out  1  sticky: unsupported instruction decoded
//  bus_err    out  1  sticky: memory timeout
// BEHAVIOUR
//  - Supported: add sub and or xor sll srl sra slt sltu (exact funct7/funct3), addi andi ori xori, lw, sw, beq, jal, lui.
//    Any other op/funct3/funct7 combination is illegal.
//  - States: FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 TRAP=7; registered, rst -> FETCH.
//  - While rst=1 every strobe (mem_req, mem_we, ir_write, pc_write, reg_write, instret) is 0; illegal, bus_err,
//    timeout counter cleared. Controls alu_op/ext_op/alu_src/npc_op/wd_sel are 0 outside DECODE..WB.
//  - FETCH: mem_req=1, iord=0. On mem_ready: ir_write=1, -> DECODE; else stay.
//  - DECODE: no strobes; illegal -> TRAP (illegal<=1), else -> EXEC.
//  - EXEC: alu_op/alu_src/ext_op from instr (lw/sw use add, beq uses sub).
//    R/I-ALU/lui -> WB. lw/sw -> MEM.
//    beq: pc_write=1, npc_op=001 if zero else 000, instret=1, -> FETCH.
//    jal: reg_write=1, wd_sel=10 (old PC+4), pc_write=1, npc_op=010, instret=1, -> FETCH.
//  - MEM: mem_req=1, iord=1, mem_we=1 for sw. On mem_ready: sw -> pc_write=1, npc_op=000, instret=1, -> FETCH;
//    lw -> WB.
//  - WB: reg_write=1, wd_sel=01 for lw else 00, pc_write=1, npc_op=000, instret=1, -> FETCH.
//  - Latency with zero-wait memory: R/I/lui 4 cycles, lw 5, sw 4, beq 3, jal 3.
//  - Timeout: counter increments each cycle mem_req=1 and mem_ready=0, clears on ready or state change.
//    Reaching MEM_TIMEOUT -> TRAP, bus_err<=1, access abandoned. Ready arriving on that same cycle wins (no error).
//  - TRAP: all strobes 0, mem_ready ignored; exit only via rst. illegal/bus_err stay set until rst.
//  - rst mid-access: mem_req/mem_we drop in the rst cycle; no pc_write/reg_write; FETCH after rst falls.
// TESTING
//  - add x3,x1,x2 (0x002081B3), ready immediate -> FETCH,DECODE,EXEC,WB; WB: reg_write=1, alu_op=00011,
//    wd_sel=00, pc_write=1; instret on cycle 4 only.
//  - lw x5,0(x0) (0x00002283), ready 3 cycles late in MEM -> mem_req=1, iord=1, mem_we=0 for 4 cycles;
//    ext_op=010000; WB wd_sel=01; 8 cycles total.
//  - beq x0,x0,8 (0x00000463): zero=1 -> EXEC pc_write=1, npc_op=001; zero=0 -> npc_op=000; 3 cycles each.
//  - ecall (0x00000073) -> TRAP after DECODE, illegal=1, mem_req stays 0 for 20 cycles; rst clears illegal, FETCH.
//  - MEM_TIMEOUT=4, fetch mem_ready never -> mem_req high 4 cycles, then state=7, bus_err=1, mem_req=0.
//  - sw x2,4(x0) with rst raised in 2nd MEM cycle -> mem_req=mem_we=0 that cycle, no pc_write, state=0 after.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the
// RV32I-subset datapath. One memory port serves both instruction and data
// accesses through a req/ready handshake.
//
// Parameters:
//   MEM_TIMEOUT  cycles mem_req may wait for mem_ready before bus_err (0 = never)
// Ports:
//   clk, rst              clock (rising edge), synchronous active-high reset
//   instr[31:0]           IR contents, valid DECODE..WB
//   zero                  ALU zero flag, used by beq in EXEC
//   mem_ready             memory acknowledge, only looked at in FETCH/MEM
//   mem_req, mem_we, iord memory request, write strobe, address select (1 = ALU)
//   ir_write, pc_write    IR load / PC <= NPC strobes
//   reg_write             register file write enable
//   alu_src, alu_op,      datapath controls (ALUOp, EXTOp one-hot, NPCOp, WDSel)
//   ext_op, npc_op, wd_sel
//   state[2:0]            FSM state for debug
//   instret               one-cycle pulse per retired instruction
//   illegal, bus_err      sticky error flags, cleared only by rst
module multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        iord,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic        alu_src,
  output logic [4:0]  alu_op,
  output logic [5:0]  ext_op,
  output logic [2:0]  npc_op,
  output logic [1:0]  wd_sel,
  output logic [2:0]  state,
  output logic        instret,
  output logic        illegal,
  output logic        bus_err
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  localparam int unsigned   TW     = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST = TW'(MEM_TIMEOUT - 1);

  state_t        cur, nxt;
  logic [TW-1:0] tcnt;
  logic          tmo_hit, set_ill, set_berr;

  logic [6:0] opcode, f7;
  logic [2:0] f3;
  logic       is_alu, is_lw, is_sw, is_beq, is_jal, legal;
  logic [4:0] dec_aop;
  logic [5:0] dec_eop;
  logic       dec_src;
  logic       instr_unused;

  assign opcode       = instr[6:0];
  assign f3           = instr[14:12];
  assign f7           = instr[31:25];
  assign instr_unused = ^{instr[24:15], instr[11:7]};

  // Instruction decode; is_alu covers R-type, I-type ALU and lui (all go EXEC -> WB).
  always_comb begin
    is_alu  = 1'b0;
    is_lw   = 1'b0;
    is_sw   = 1'b0;
    is_beq  = 1'b0;
    is_jal  = 1'b0;
    dec_aop = '0;
    dec_eop = '0;
    dec_src = 1'b0;
    case (opcode)
      7'b0110011: begin
        if (f7 == 7'b0000000) begin
          is_alu = 1'b1;
          case (f3)
            3'b000:  dec_aop = 5'b00011;
            3'b001:  dec_aop = 5'b01111;
            3'b010:  dec_aop = 5'b01010;
            3'b011:  dec_aop = 5'b01011;
            3'b100:  dec_aop = 5'b01100;
            3'b101:  dec_aop = 5'b10000;
            3'b110:  dec_aop = 5'b01101;
            default: dec_aop = 5'b01110;
          endcase
        end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
          is_alu  = 1'b1;
          dec_aop = 5'b00100;
        end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
          is_alu  = 1'b1;
          dec_aop = 5'b10001;
        end
      end
      7'b0010011: begin
        dec_eop = 6'b010000;
        dec_src = 1'b1;
        case (f3)
          3'b000: begin is_alu = 1'b1; dec_aop = 5'b00011; end
          3'b100: begin is_alu = 1'b1; dec_aop = 5'b01100; end
          3'b110: begin is_alu = 1'b1; dec_aop = 5'b01101; end
          3'b111: begin is_alu = 1'b1; dec_aop = 5'b01110; end
          default: ;
        endcase
      end
      7'b0000011: if (f3 == 3'b010) begin
        is_lw = 1'b1; dec_aop = 5'b00011; dec_eop = 6'b010000; dec_src = 1'b1;
      end
      7'b0100011: if (f3 == 3'b010) begin
        is_sw = 1'b1; dec_aop = 5'b00011; dec_eop = 6'b001000; dec_src = 1'b1;
      end
      7'b1100011: if (f3 == 3'b000) begin
        is_beq = 1'b1; dec_aop = 5'b00100; dec_eop = 6'b000100;
      end
      7'b1101111: begin
        is_jal = 1'b1; dec_eop = 6'b000001;
      end
      7'b0110111: begin
        is_alu = 1'b1; dec_aop = 5'b00001; dec_eop = 6'b000010; dec_src = 1'b1;
      end
      default: ;
    endcase
  end

  assign legal = is_alu | is_lw | is_sw | is_beq | is_jal;

  // Ready on the final allowed cycle wins over the timeout.
  assign tmo_hit = (MEM_TIMEOUT != 0) && !mem_ready && (tcnt == T_LAST);

  always_comb begin
    nxt       = cur;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    iord      = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    reg_write = 1'b0;
    alu_src   = 1'b0;
    alu_op    = '0;
    ext_op    = '0;
    npc_op    = '0;
    wd_sel    = '0;
    instret   = 1'b0;
    set_ill   = 1'b0;
    set_berr  = 1'b0;
    if (rst) begin
      nxt = S_FETCH;
    end else begin
      if (cur inside {S_DECODE, S_EXEC, S_MEM, S_WB}) begin
        alu_op  = dec_aop;
        ext_op  = dec_eop;
        alu_src = dec_src;
      end
      case (cur)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            nxt      = S_DECODE;
          end else if (tmo_hit) begin
            set_berr = 1'b1;
            nxt      = S_TRAP;
          end
        end
        S_DECODE: begin
          if (!legal) begin
            set_ill = 1'b1;
            nxt     = S_TRAP;
          end else begin
            nxt = S_EXEC;
          end
        end
        S_EXEC: begin
          if (is_beq) begin
            pc_write = 1'b1;
            npc_op   = zero ? 3'b001 : 3'b000;
            instret  = 1'b1;
            nxt      = S_FETCH;
          end else if (is_jal) begin
            reg_write = 1'b1;
            wd_sel    = 2'b10;
            pc_write  = 1'b1;
            npc_op    = 3'b010;
            instret   = 1'b1;
            nxt       = S_FETCH;
          end else if (is_lw || is_sw) begin
            nxt = S_MEM;
          end else begin
            nxt = S_WB;
          end
        end
        S_MEM: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          mem_we  = is_sw;
          if (mem_ready) begin
            if (is_sw) begin
              pc_write = 1'b1;
              instret  = 1'b1;
              nxt      = S_FETCH;
            end else begin
              nxt = S_WB;
            end
          end else if (tmo_hit) begin
            set_berr = 1'b1;
            nxt      = S_TRAP;
          end
        end
        S_WB: begin
          reg_write = 1'b1;
          wd_sel    = is_lw ? 2'b01 : 2'b00;
          pc_write  = 1'b1;
          instret   = 1'b1;
          nxt       = S_FETCH;
        end
        S_TRAP:  nxt = S_TRAP;
        default: nxt = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur     <= S_FETCH;
      illegal <= 1'b0;
      bus_err <= 1'b0;
      tcnt    <= '0;
    end else begin
      cur <= nxt;
      if (set_ill)  illegal <= 1'b1;
      if (set_berr) bus_err <= 1'b1;
      if (nxt != cur || !mem_req || mem_ready) tcnt <= '0;
      else                                      tcnt <= tcnt + 1'b1;
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed-vector bench for multicycle_ctrl with a
// per-cycle scoreboard. The driver applies inputs just after each rising edge
// and queues the expected output vector with a care mask; the monitor pops
// and compares on the falling edge.
module tb_multicycle_ctrl;

  localparam int TMO = 4;
  localparam int K_ALU = 0, K_LW = 1, K_SW = 2, K_BEQ = 3, K_JAL = 4, K_ILL = 5;

  typedef struct packed {
    logic [2:0] st;
    logic       req, we, iord, irw, pcw, rgw, src;
    logic [4:0] aop;
    logic [5:0] eop;
    logic [2:0] nop;
    logic [1:0] wds;
    logic       ret, ill, berr;
  } vec_t;

  typedef struct packed {
    logic [95:0] name;
    vec_t        v;
    vec_t        m;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = '0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_we, iord, ir_write, pc_write, reg_write, alu_src;
  logic [4:0]  alu_op;
  logic [5:0]  ext_op;
  logic [2:0]  npc_op;
  logic [1:0]  wd_sel;
  logic [2:0]  state;
  logic        instret, illegal, bus_err;

  exp_t q[$];
  exp_t mx;
  vec_t act;
  int   n_checks = 0;
  int   n_fail = 0;
  logic exp_ill = 1'b0;
  logic exp_berr = 1'b0;

  multicycle_ctrl #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .instr(instr), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .reg_write(reg_write), .alu_src(alu_src),
    .alu_op(alu_op), .ext_op(ext_op), .npc_op(npc_op), .wd_sel(wd_sel),
    .state(state), .instret(instret), .illegal(illegal), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  // Monitor: one expected vector per clock cycle.
  always @(negedge clk) begin
    if (q.size() != 0) begin
      mx  = q.pop_front();
      act = {state, mem_req, mem_we, iord, ir_write, pc_write, reg_write, alu_src,
             alu_op, ext_op, npc_op, wd_sel, instret, illegal, bus_err};
      n_checks++;
      if (((act ^ mx.v) & mx.m) != '0) begin
        n_fail++;
        $display("FAIL %0s: got %h required %h (care %h) at %0t", mx.name, act, mx.v, mx.m, $time);
      end
    end
  end

  function automatic vec_t zv(input logic [2:0] st);
    vec_t v;
    v      = '0;
    v.st   = st;
    v.ill  = exp_ill;
    v.berr = exp_berr;
    return v;
  endfunction

  task automatic cyc(input logic [95:0] nm, input logic r, input logic rdy, input logic z,
                     input logic [31:0] ins, input vec_t v, input vec_t m);
    exp_t x;
    @(posedge clk);
    #1;
    rst       = r;
    mem_ready = rdy;
    zero      = z;
    instr     = ins;
    x.name = nm;
    x.v    = v;
    x.m    = m;
    q.push_back(x);
  endtask

  task automatic do_reset(input int n);
    vec_t v, m;
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        exp_ill  = 1'b0;
        exp_berr = 1'b0;
      end
      v = zv(3'd0);
      m = '1;
      m.aop = '0; m.eop = '0; m.src = 1'b0; m.nop = '0; m.wds = '0; m.iord = 1'b0;
      if (i == 0) begin
        m.st = '0; m.ill = 1'b0; m.berr = 1'b0;
      end
      cyc("reset", 1'b1, 1'b0, 1'b0, instr, v, m);
    end
  endtask

  task automatic trap(input int n);
    vec_t v;
    for (int i = 0; i < n; i++) begin
      v = zv(3'd7);
      cyc("trap", 1'b0, i[0], 1'b0, instr, v, '1);
    end
  endtask

  // fw/mw: wait cycles before mem_ready in FETCH/MEM; mw < 0 means never ready.
  // rst_at: MEM cycle index in which rst is raised (-1 = none).
  task automatic do_instr(input logic [95:0] nm, input logic [31:0] ins, input int kind,
                          input logic [4:0] aop, input logic [5:0] eop, input logic src,
                          input int fw, input int mw, input logic z, input int rst_at);
    vec_t v, m;
    for (int i = 0; i <= fw; i++) begin
      v = zv(3'd0); v.req = 1'b1; v.irw = (i == fw);
      cyc(nm, 1'b0, (i == fw), 1'b0, ins, v, '1);
    end
    v = zv(3'd1);
    m = '1; m.aop = '0; m.eop = '0; m.src = 1'b0; m.nop = '0; m.wds = '0; m.iord = 1'b0;
    cyc(nm, 1'b0, 1'b1, 1'b0, ins, v, m);
    if (kind == K_ILL) begin
      exp_ill = 1'b1;
      return;
    end
    v = zv(3'd2); v.aop = aop; v.eop = eop; v.src = src;
    m = '1; m.iord = 1'b0; m.nop = '0; m.wds = '0;
    if (kind == K_BEQ) begin
      v.pcw = 1'b1; v.ret = 1'b1; v.nop = z ? 3'b001 : 3'b000; m.nop = '1;
    end
    if (kind == K_JAL) begin
      v.rgw = 1'b1; v.wds = 2'b10; v.pcw = 1'b1; v.nop = 3'b010; v.ret = 1'b1;
      m.nop = '1; m.wds = '1;
    end
    cyc(nm, 1'b0, 1'b0, z, ins, v, m);
    if (kind == K_BEQ || kind == K_JAL) return;
    if (kind == K_LW || kind == K_SW) begin
      m = '1; m.nop = '0; m.wds = '0;
      if (mw < 0) begin
        for (int i = 0; i < TMO; i++) begin
          v = zv(3'd3); v.req = 1'b1; v.iord = 1'b1; v.we = (kind == K_SW);
          v.aop = aop; v.eop = eop; v.src = src;
          cyc(nm, 1'b0, 1'b0, 1'b0, ins, v, m);
        end
        exp_berr = 1'b1;
        return;
      end
      for (int i = 0; i <= mw; i++) begin
        if (i == rst_at) begin
          v = zv(3'd3);
          m = '1; m.aop = '0; m.eop = '0; m.src = 1'b0; m.nop = '0; m.wds = '0; m.iord = 1'b0;
          cyc(nm, 1'b1, 1'b0, 1'b0, ins, v, m);
          return;
        end
        v = zv(3'd3); v.req = 1'b1; v.iord = 1'b1; v.we = (kind == K_SW);
        v.aop = aop; v.eop = eop; v.src = src;
        m = '1; m.nop = '0; m.wds = '0;
        if (i == mw && kind == K_SW) begin
          v.pcw = 1'b1; v.ret = 1'b1; m.nop = '1;
        end
        cyc(nm, 1'b0, (i == mw), 1'b0, ins, v, m);
      end
      if (kind == K_SW) return;
    end
    v = zv(3'd4); v.rgw = 1'b1; v.pcw = 1'b1; v.ret = 1'b1;
    v.wds = (kind == K_LW) ? 2'b01 : 2'b00;
    v.aop = aop; v.eop = eop; v.src = src;
    m = '1; m.iord = 1'b0;
    cyc(nm, 1'b0, 1'b0, 1'b0, ins, v, m);
  endtask

  initial begin
    logic [31:0] ill_tab [4];
    vec_t v;
    ill_tab = '{32'h00000073, 32'h022081B3, 32'h00109093, 32'h00000283};

    do_reset(2);
    do_instr("add",   32'h002081B3, K_ALU, 5'b00011, 6'b000000, 1'b0, 0, 0, 1'b0, -1);
    do_instr("lw",    32'h00002283, K_LW,  5'b00011, 6'b010000, 1'b1, 0, 3, 1'b0, -1);
    do_instr("sw",    32'h00202223, K_SW,  5'b00011, 6'b001000, 1'b1, 1, 0, 1'b0, -1);
    do_instr("beq_t", 32'h00000463, K_BEQ, 5'b00100, 6'b000100, 1'b0, 0, 0, 1'b1, -1);
    do_instr("beq_n", 32'h00000463, K_BEQ, 5'b00100, 6'b000100, 1'b0, 2, 0, 1'b0, -1);
    do_instr("jal",   32'h008000EF, K_JAL, 5'b00000, 6'b000001, 1'b0, 0, 0, 1'b0, -1);
    do_instr("lui",   32'h123452B7, K_ALU, 5'b00001, 6'b000010, 1'b1, 0, 0, 1'b0, -1);
    do_instr("sub",   32'h402081B3, K_ALU, 5'b00100, 6'b000000, 1'b0, 0, 0, 1'b0, -1);
    do_instr("sra",   32'h4020D1B3, K_ALU, 5'b10001, 6'b000000, 1'b0, 0, 0, 1'b0, -1);
    do_instr("srl",   32'h0020D1B3, K_ALU, 5'b10000, 6'b000000, 1'b0, 0, 0, 1'b0, -1);
    do_instr("and",   32'h0020F1B3, K_ALU, 5'b01110, 6'b000000, 1'b0, 0, 0, 1'b0, -1);
    do_instr("sltu",  32'h0020B1B3, K_ALU, 5'b01011, 6'b000000, 1'b0, 0, 0, 1'b0, -1);
    do_instr("addi",  32'h00500093, K_ALU, 5'b00011, 6'b010000, 1'b1, 0, 0, 1'b0, -1);
    do_instr("xori",  32'h00504093, K_ALU, 5'b01100, 6'b010000, 1'b1, 0, 0, 1'b0, -1);
    do_instr("ori",   32'h00506093, K_ALU, 5'b01101, 6'b010000, 1'b1, 0, 0, 1'b0, -1);

    // Unsupported encodings: ecall, mul, slli, lb.
    foreach (ill_tab[k]) begin
      do_instr("illegal", ill_tab[k], K_ILL, 5'b00000, 6'b000000, 1'b0, 0, 0, 1'b0, -1);
      trap((k == 0) ? 20 : 3);
      do_reset(2);
    end

    // Fetch never acknowledged.
    for (int i = 0; i < TMO; i++) begin
      v = zv(3'd0); v.req = 1'b1;
      cyc("fetch_tmo", 1'b0, 1'b0, 1'b0, 32'h0, v, '1);
    end
    exp_berr = 1'b1;
    trap(3);
    do_reset(2);

    // Load data phase never acknowledged.
    do_instr("lw_tmo", 32'h00002283, K_LW, 5'b00011, 6'b010000, 1'b1, 0, -1, 1'b0, -1);
    trap(3);
    do_reset(2);

    // Reset during the second MEM cycle of a store, then a clean fetch.
    do_instr("sw_rst", 32'h00202223, K_SW,  5'b00011, 6'b001000, 1'b1, 0, 5, 1'b0, 1);
    do_instr("add2",   32'h002081B3, K_ALU, 5'b00011, 6'b000000, 1'b0, 0, 0, 1'b0, -1);

    repeat (3) @(negedge clk);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected vectors left, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within 100000 time units");
    $fatal(1);
  end

endmodule
